// File: rtl/mul_ctrl.sv
// Issue/retire controller for RV64M multiplies sitting in front of the radix-4 Booth multiplier.
// Runs one operation at a time, applies the unsigned/mixed-sign high-word correction, and holds the result.
module mul_ctrl #(
  parameter int TAG_W       = 5,
  parameter int ZERO_BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [63:0]      in_src1,
  input  logic [63:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             mul_valid,
  input  logic             mul_ready,
  output logic [63:0]      multiplicand,
  output logic [63:0]      multiplier,
  input  logic             mul_out_valid,
  input  logic [63:0]      result_hi,
  input  logic [63:0]      result_lo,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [63:0]        prod_hi_q;
  logic [63:0]        prod_lo_q;
  logic [63:0]        result_q;

  logic               accept;
  logic [2:0]         op_in;
  logic [63:0]        src_a;
  logic [63:0]        src_b;
  logic               bypass;
  logic [63:0]        fix_result;

  // Handshakes: a transfer happens on any cycle where valid & ready are both high.
  // valid never depends on ready; once raised it stays up until the transfer.
  // mul_out_valid is a one-cycle pulse with no back-pressure.
  assign in_ready  = (state == IDLE) & ~flush;
  assign accept    = in_valid & in_ready;
  assign mul_valid = (state == ISSUE);
  assign out_valid = (state == DONE);

  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign state_dbg  = state;

  // Reserved opcodes behave as MUL; MULW works on sign-extended low words.
  always_comb begin
    op_in  = (in_op > OP_MULW) ? OP_MUL : in_op;
    src_a  = in_src1;
    src_b  = in_src2;
    if (op_in == OP_MULW) begin
      src_a = {{32{in_src1[31]}}, in_src1[31:0]};
      src_b = {{32{in_src2[31]}}, in_src2[31:0]};
    end
    bypass = (ZERO_BYPASS != 0) && ((src_a == 64'd0) || (src_b == 64'd0));
  end

  // The multiplier returns the signed x signed product; unsigned views add back
  // the operand shifted by 64 for each operand whose sign bit was set.
  always_comb begin
    fix_result = prod_lo_q;
    case (op_q)
      OP_MUL:    fix_result = prod_lo_q;
      OP_MULH:   fix_result = prod_hi_q;
      OP_MULHSU: fix_result = prod_hi_q + (multiplier[63] ? multiplicand : 64'd0);
      OP_MULHU:  fix_result = prod_hi_q
                              + (multiplicand[63] ? multiplier : 64'd0)
                              + (multiplier[63] ? multiplicand : 64'd0);
      OP_MULW:   fix_result = {{32{prod_lo_q[31]}}, prod_lo_q[31:0]};
      default:   fix_result = prod_lo_q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = bypass ? DONE : ISSUE;
      end
      ISSUE: begin
        if (flush)          state_nxt = mul_ready ? DRAIN : IDLE;
        else if (mul_ready) state_nxt = WAIT;
      end
      WAIT: begin
        // A product landing in the flush cycle is simply dropped.
        if (mul_out_valid) state_nxt = flush ? IDLE : FIX;
        else if (flush)    state_nxt = DRAIN;
      end
      FIX: begin
        state_nxt = flush ? IDLE : DONE;
      end
      DONE: begin
        if (flush || out_ready) state_nxt = IDLE;
      end
      DRAIN: begin
        if (mul_out_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= OP_MUL;
      tag_q        <= '0;
      multiplicand <= 64'd0;
      multiplier   <= 64'd0;
      prod_hi_q    <= 64'd0;
      prod_lo_q    <= 64'd0;
      result_q     <= 64'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q         <= op_in;
        tag_q        <= in_tag;
        multiplicand <= src_a;
        multiplier   <= src_b;
        if (bypass) result_q <= 64'd0;
      end
      if ((state == WAIT) && mul_out_valid && !flush) begin
        prod_hi_q <= result_hi;
        prod_lo_q <= result_lo;
      end
      if ((state == FIX) && !flush) result_q <= fix_result;
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural stand-in for the Booth multiplier.
module tb_mul_ctrl;

  localparam int TAG_W = 5;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [63:0]      in_src1;
  logic [63:0]      in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             mul_valid;
  logic             mul_ready;
  logic [63:0]      multiplicand;
  logic [63:0]      multiplier;
  logic             mul_out_valid;
  logic [63:0]      result_hi;
  logic [63:0]      result_lo;
  logic [2:0]       state_dbg;

  int checks;
  int errors;

  // multiplier stand-in: signed 64x64 product, pulse mul_lat cycles after the handshake
  int          mul_lat;
  int          cnt;
  logic        busy;
  logic        model_pulse;
  logic [63:0] model_hi;
  logic [63:0] model_lo;
  logic        spur;
  logic [63:0] spur_hi;
  logic [63:0] spur_lo;

  assign mul_out_valid = model_pulse | spur;
  assign result_hi     = spur ? spur_hi : model_hi;
  assign result_lo     = spur ? spur_lo : model_lo;

  mul_ctrl #(.TAG_W(TAG_W), .ZERO_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .mul_valid(mul_valid), .mul_ready(mul_ready),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_out_valid(mul_out_valid), .result_hi(result_hi), .result_lo(result_lo),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      model_pulse <= 1'b0;
      busy        <= 1'b0;
      cnt         <= 0;
      model_hi    <= 64'd0;
      model_lo    <= 64'd0;
    end else begin
      model_pulse <= 1'b0;
      if (busy) begin
        if (cnt == 1) begin
          model_pulse <= 1'b1;
          busy        <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end else if (mul_valid && mul_ready) begin
        {model_hi, model_lo} <= $signed({{64{multiplicand[63]}}, multiplicand})
                              * $signed({{64{multiplier[63]}}, multiplier});
        if (mul_lat == 1) model_pulse <= 1'b1;
        else begin
          busy <= 1'b1;
          cnt  <= mul_lat - 1;
        end
      end
    end
  end

  // driver tasks
  task automatic start_op(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [TAG_W-1:0] tg);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2; in_tag = tg;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // counts cycles after the accept edge until out_valid, bounded
  task automatic wait_done(output int lat, output int mv);
    mv = 0;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk);
      if (mul_valid && mul_ready) mv++;
      if (out_valid) break;
    end
  endtask

  task automatic take_result();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_src1 = 64'd0;
    in_src2 = 64'd0; in_tag = '0; out_ready = 1'b0; mul_ready = 1'b1; mul_lat = 3;
    spur = 1'b0; spur_hi = 64'd0; spur_lo = 64'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_result !== 64'd0) begin errors++; $display("FAIL reset_out_result got %h exp 0", out_result); end
    checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL reset_out_tag got %h exp 0", out_tag); end
    checks++; if (mul_valid !== 1'b0) begin errors++; $display("FAIL reset_mul_valid got %b exp 0", mul_valid); end
    checks++; if (multiplicand !== 64'd0) begin errors++; $display("FAIL reset_multiplicand got %h exp 0", multiplicand); end
    checks++; if (multiplier !== 64'd0) begin errors++; $display("FAIL reset_multiplier got %h exp 0", multiplier); end
  endtask

  task automatic test_mulhu();
    int lat, mv; logic [63:0] res; logic [TAG_W-1:0] tg;
    start_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1);
    wait_done(lat, mv); res = out_result; tg = out_tag;
    take_result();
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulhu_result got %h exp fffffffffffffffe", res); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL mulhu_latency got %0d exp 6", lat); end
    checks++; if (mv !== 1) begin errors++; $display("FAIL mulhu_mul_handshakes got %0d exp 1", mv); end
    checks++; if (tg !== 5'd1) begin errors++; $display("FAIL mulhu_tag got %h exp 01", tg); end
  endtask

  task automatic test_mulhsu_mulh();
    int lat, mv; logic [63:0] res;
    start_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 5'd2);
    wait_done(lat, mv); res = out_result; take_result();
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulhsu_result got %h exp ffffffffffffffff", res); end
    start_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 5'd3);
    wait_done(lat, mv); res = out_result; take_result();
    checks++; if (res !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL mulh_result got %h exp 0000000000000001", res); end
  endtask

  task automatic test_mulw_mul();
    int lat, mv; logic [63:0] res, mc, mp;
    start_op(3'd4, 64'h1_0000_0003, 64'h0000_0000_7FFF_FFFF, 5'd4);
    mc = multiplicand; mp = multiplier;
    wait_done(lat, mv); res = out_result; take_result();
    checks++; if (mc !== 64'h3) begin errors++; $display("FAIL mulw_multiplicand got %h exp 3", mc); end
    checks++; if (mp !== 64'h7FFF_FFFF) begin errors++; $display("FAIL mulw_multiplier got %h exp 7fffffff", mp); end
    checks++; if (res !== 64'h0000_0000_7FFF_FFFD) begin errors++; $display("FAIL mulw_result got %h exp 000000007ffffffd", res); end
    start_op(3'd4, 64'h0000_0000_FFFF_FFFF, 64'd2, 5'd5);
    mc = multiplicand;
    wait_done(lat, mv); res = out_result; take_result();
    checks++; if (mc !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulw_neg_multiplicand got %h exp ffffffffffffffff", mc); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulw_neg_result got %h exp fffffffffffffffe", res); end
    start_op(3'd0, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 5'd6);
    wait_done(lat, mv); res = out_result; take_result();
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFD6) begin errors++; $display("FAIL mul_result got %h exp ffffffffffffffd6", res); end
  endtask

  task automatic test_op_alias();
    int lat, mv; logic [63:0] res;
    start_op(3'd7, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 5'd7);
    wait_done(lat, mv); res = out_result; take_result();
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFD6) begin errors++; $display("FAIL op7_as_mul got %h exp ffffffffffffffd6", res); end
  endtask

  task automatic test_zero_bypass();
    int lat, mv; logic [63:0] res; logic [TAG_W-1:0] tg;
    start_op(3'd0, 64'd0, 64'd5, 5'd8);
    wait_done(lat, mv); res = out_result; tg = out_tag; take_result();
    checks++; if (lat !== 1) begin errors++; $display("FAIL bypass_latency got %0d exp 1", lat); end
    checks++; if (mv !== 0) begin errors++; $display("FAIL bypass_mul_handshakes got %0d exp 0", mv); end
    checks++; if (res !== 64'd0) begin errors++; $display("FAIL bypass_result got %h exp 0", res); end
    checks++; if (tg !== 5'd8) begin errors++; $display("FAIL bypass_tag got %h exp 08", tg); end
    start_op(3'd4, 64'h1_0000_0000, 64'd5, 5'd9);
    wait_done(lat, mv); res = out_result; take_result();
    checks++; if (lat !== 1 || mv !== 0) begin errors++; $display("FAIL bypass_mulw got lat %0d hs %0d exp lat 1 hs 0", lat, mv); end
  endtask

  task automatic test_flush_wait();
    int lat, mv; logic [63:0] res; logic [TAG_W-1:0] tg;
    mul_lat = 8;
    start_op(3'd0, 64'd5, 64'd5, 5'd10);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL drain_cycle%0d got in_ready %b out_valid %b exp 0 0", i, in_ready, out_valid);
      end
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_exit got in_ready %b out_valid %b exp 1 0", in_ready, out_valid); end
    mul_lat = 3;
    start_op(3'd0, 64'd3, 64'd4, 5'd11);
    wait_done(lat, mv); res = out_result; tg = out_tag; take_result();
    checks++; if (res !== 64'd12) begin errors++; $display("FAIL after_flush_result got %h exp c", res); end
    checks++; if (tg !== 5'd11) begin errors++; $display("FAIL after_flush_tag got %h exp 0b", tg); end
  endtask

  task automatic test_flush_issue();
    mul_ready = 1'b0;
    start_op(3'd0, 64'd9, 64'd9, 5'd12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mul_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL issue_hold%0d got mul_valid %b in_ready %b exp 1 0", i, mul_valid, in_ready);
      end
    end
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    mul_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || mul_valid !== 1'b0) begin errors++; $display("FAIL issue_flush got in_ready %b mul_valid %b exp 1 0", in_ready, mul_valid); end
  endtask

  task automatic test_flush_accept_same();
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_src1 = 64'd2; in_src2 = 64'd3; in_tag = 5'd13;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || mul_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_beats_accept got in_ready %b mul_valid %b out_valid %b exp 1 0 0", in_ready, mul_valid, out_valid);
    end
  endtask

  task automatic test_flush_done();
    int lat, mv;
    start_op(3'd0, 64'd2, 64'd3, 5'd14);
    wait_done(lat, mv);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_done got out_valid %b in_ready %b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_hold_done();
    int lat, mv;
    start_op(3'd0, 64'd7, 64'd8, 5'd21);
    wait_done(lat, mv);
    checks++; if (lat !== 6) begin errors++; $display("FAIL hold_latency got %0d exp 6", lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      spur = (i == 5); spur_hi = 64'hDEAD_BEEF_0000_0001; spur_lo = 64'hCAFE_F00D_0000_0002;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 64'd56 || out_tag !== 5'd21 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d got v %b res %h tag %h rdy %b exp 1 38 15 0", i, out_valid, out_result, out_tag, in_ready);
      end
    end
    @(posedge clk); #1 spur = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got out_valid %b in_ready %b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat, mv; logic [63:0] res;
    mul_lat = 1;
    start_op(3'd0, 64'h1_2345_6789, 64'h1000, 5'd16);
    wait_done(lat, mv); res = out_result; take_result();
    checks++; if (res !== 64'h1234_5678_9000) begin errors++; $display("FAIL b2b_first got %h exp 123456789000", res); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", lat); end
    start_op(3'd1, 64'h4000_0000_0000_0000, 64'd4, 5'd17);
    wait_done(lat, mv); res = out_result; take_result();
    checks++; if (res !== 64'd1) begin errors++; $display("FAIL b2b_second got %h exp 1", res); end
    mul_lat = 3;
  endtask

  task automatic test_reset_mid();
    mul_lat = 8;
    start_op(3'd0, 64'd9, 64'd9, 5'd18);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || multiplicand !== 64'd0) begin
      errors++; $display("FAIL reset_mid got in_ready %b out_valid %b mcand %h exp 1 0 0", in_ready, out_valid, multiplicand);
    end
    mul_lat = 3;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mulhu();
    test_mulhsu_mulh();
    test_mulw_mul();
    test_op_alias();
    test_zero_bypass();
    test_flush_wait();
    test_flush_issue();
    test_flush_accept_same();
    test_flush_done();
    test_hold_done();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
